indec_until_delim_1_1_16_8: RTL and testbench

//  Receive-side counterpart of the decimal output routines. Consumes ASCII bytes from
//  the UART receiver module, one byte per rx_valid strobe. Accumulates decimal digits

---
 rtl/indec_until_delim_1_1_16_8_if.sv | 33 +++
 rtl/indec_until_delim_1_1_16_8.sv | 94 +++++++++
 tb/tb_indec_until_delim_1_1_16_8.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/indec_until_delim_1_1_16_8_if.sv
// Byte-in / number-out handshake bundle for the decimal input parser.
// The master drives start and the rx byte stream; the slave returns the parse.
interface indec_until_delim_1_1_16_8_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [WIDTH-1:0] result;
  logic [7:0]       delim;
  logic             overflow;
  logic             result_ready;

  modport master (
    output start,
    output rx_data,
    output rx_valid,
    input  result,
    input  delim,
    input  overflow,
    input  result_ready
  );

  modport slave (
    input  start,
    input  rx_data,
    input  rx_valid,
    output result,
    output delim,
    output overflow,
    output result_ready
  );
endinterface

// File: rtl/indec_until_delim_1_1_16_8.sv
// Decimal input parser: skips leading non-digits, accumulates digits with
// saturation, and reports the value plus the terminating delimiter byte.
module indec_until_delim_1_1_16_8 #(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic reset,
  indec_until_delim_1_1_16_8_if.slave bus
);

  localparam int XW = WIDTH + 4;

  typedef enum logic [1:0] {
    ST_READY,
    ST_SKIP,
    ST_ACCUM
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] result;
  logic [7:0]       delim;
  logic             overflow;

  logic             is_digit;
  logic [3:0]       digit;
  logic [XW-1:0]    ext;
  logic [XW-1:0]    sum;
  logic             sat;
  logic [WIDTH-1:0] next_acc;

  assign is_digit = (bus.rx_data >= 8'h30)
                 && (bus.rx_data <= 8'h39);

  // For '0'..'9' the low nibble equals rx_data - 48.
  assign digit = bus.rx_data[3:0];

  assign ext = {4'b0000, acc};
  assign sum = (ext << 3) + (ext << 1)
             + {{(XW-4){1'b0}}, digit};

  // Anything above WIDTH bits means the value exceeded 2^WIDTH-1.
  assign sat      = |sum[XW-1:WIDTH];
  assign next_acc = sat ? {WIDTH{1'b1}}
                        : sum[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_READY;
      acc      <= '0;
      result   <= '0;
      delim    <= '0;
      overflow <= 1'b0;
    end else if (bus.start) begin
      state    <= ST_SKIP;
      acc      <= '0;
      result   <= '0;
      delim    <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        ST_READY: begin
        end
        ST_SKIP: begin
          if (bus.rx_valid && is_digit) begin
            acc   <= {{(WIDTH-4){1'b0}}, digit};
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (bus.rx_valid) begin
            if (is_digit) begin
              acc <= next_acc;
              if (sat)
                overflow <= 1'b1;
            end else begin
              result <= acc;
              delim  <= bus.rx_data;
              state  <= ST_READY;
            end
          end
        end
        default: state <= ST_READY;
      endcase
    end
  end

  assign bus.result       = result;
  assign bus.delim        = delim;
  assign bus.overflow     = overflow;
  assign bus.result_ready = (state == ST_READY)
                          & ~bus.start;

endmodule

// File: tb/tb_indec_until_delim_1_1_16_8.sv
// Bench for the decimal input parser: table of byte strings with a
// result scoreboard, plus hand sequences for abort/reset/discard cases.
module tb_indec_until_delim_1_1_16_8;

  logic clk;
  logic reset;

  indec_until_delim_1_1_16_8_if #(.WIDTH(16)) bus ();

  indec_until_delim_1_1_16_8 #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       s;
    bit          gap;
    logic [15:0] res;
    logic [7:0]  dl;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [7:0]  dl;
    logic        ov;
  } exp_t;

  vec_t vecs [8];
  exp_t sb [$];
  int   checks;
  int   failures;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic pulse_start(input logic with_byte,
                             input logic [7:0] b);
    bus.start    = 1'b1;
    bus.rx_valid = with_byte;
    bus.rx_data  = b;
    #1;
    chk("start_mask", {31'b0, bus.result_ready}, 32'd0);
    tick();
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic collect(input string name);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.result_ready && n < 8) begin
      tick();
      n++;
    end
    chk({name, "_latency"}, n, 0);
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({name, "_result"}, {16'b0, bus.result}, {16'b0, e.res});
    chk({name, "_delim"}, {24'b0, bus.delim}, {24'b0, e.dl});
    chk({name, "_ovf"}, {31'b0, bus.overflow}, {31'b0, e.ov});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    vecs[0] = '{"1234 ",      1'b1, 16'd1234,  8'h20, 1'b0};
    vecs[1] = '{"\r\n7\r",    1'b1, 16'd7,     8'h0D, 1'b0};
    vecs[2] = '{"65535,",     1'b0, 16'd65535, 8'h2C, 1'b0};
    vecs[3] = '{"65536,",     1'b0, 16'd65535, 8'h2C, 1'b1};
    vecs[4] = '{"3000;",      1'b0, 16'd3000,  8'h3B, 1'b0};
    vecs[5] = '{"  0x",       1'b1, 16'd0,     8'h78, 1'b0};
    vecs[6] = '{"99999999A",  1'b0, 16'd65535, 8'h41, 1'b1};
    vecs[7] = '{"0065535\n",  1'b1, 16'd65535, 8'h0A, 1'b0};

    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_result", {16'b0, bus.result}, 32'd0);
    chk("rst_delim", {24'b0, bus.delim}, 32'd0);
    chk("rst_ovf", {31'b0, bus.overflow}, 32'd0);
    chk("rst_ready", {31'b0, bus.result_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      pulse_start(1'b0, 8'h00);
      sb.push_back('{vecs[i].res, vecs[i].dl, vecs[i].ov});
      chk($sformatf("v%0d_busy", i),
          {31'b0, bus.result_ready}, 32'd0);
      for (int k = 0; k < vecs[i].s.len(); k++) begin
        send(vecs[i].s[k]);
        if (vecs[i].gap)
          tick();
      end
      collect($sformatf("v%0d", i));
    end

    // Abort mid-number and restart cleanly.
    pulse_start(1'b0, 8'h00);
    send("9");
    send("8");
    sb.push_back('{16'd42, 8'h0A, 1'b0});
    pulse_start(1'b0, 8'h00);
    send("4");
    send("2");
    send(8'h0A);
    collect("abort");

    // A byte coincident with start must be dropped.
    sb.push_back('{16'd1, 8'h3B, 1'b0});
    pulse_start(1'b1, "9");
    send("1");
    send(";");
    collect("coincide");

    // Bytes while idle are ignored.
    send("5");
    send("6");
    send(";");
    chk("idle_result", {16'b0, bus.result}, 32'd1);
    chk("idle_delim", {24'b0, bus.delim}, 32'h3B);
    chk("idle_ready", {31'b0, bus.result_ready}, 32'd1);

    // Reset mid-number.
    pulse_start(1'b0, 8'h00);
    send("7");
    send("7");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_result", {16'b0, bus.result}, 32'd0);
    chk("midrst_delim", {24'b0, bus.delim}, 32'd0);
    chk("midrst_ovf", {31'b0, bus.overflow}, 32'd0);
    chk("midrst_ready", {31'b0, bus.result_ready}, 32'd1);
    send("3");
    send(",");
    chk("postrst_result", {16'b0, bus.result}, 32'd0);
    chk("postrst_ready", {31'b0, bus.result_ready}, 32'd1);

    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
